// File: rtl/spi_slave_apb_sequencer.sv
// spi_slave_apb_sequencer
// Turns SPI command frames into APB master transfers in the system clock domain.
// One command per SPI frame selects the burst direction and the start word address.
// Write bursts stream each received word out as one APB write.
// Read bursts prefetch one APB read at a time into the TX stream.
// The word address advances after every completed beat.
//
// Optional feature macro: SPI_APB_WRAP_EN.
//   Defined:   wrap_length (in beats, 0 = off) returns the address to the start address.
//   Undefined: the address increments linearly, modulo 2^ADDR_WIDTH.
//
// Ports:
//   sys_clk, sys_rst           clock, synchronous active-high reset
//   cmd_valid/ready, cmd_rd_wr, cmd_addr
//                              command handshake: 1 = read burst, plus start address
//   wr_valid/ready, wr_data    write-word stream from SPI
//   rd_valid/ready, rd_data    read-word stream to SPI; rd_data is registered
//   cs_end                     one-cycle pulse marking the end of the SPI frame
//   wrap_length                burst wrap length in beats
//   psel, penable, pwrite, paddr, pwdata
//                              APB request outputs, all registered
//   prdata, pready, pslverr    APB response inputs
//   err_sticky, err_clr        sticky slave-error flag and its clear input
module spi_slave_apb_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] APB_BASE = '0
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_rd_wr,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  input  logic                      cs_end,
  input  logic [15:0]               wrap_length,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pready,
  input  logic                      pslverr,
  output logic                      err_sticky,
  input  logic                      err_clr
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_WAIT, SETUP, ACCESS, RD_PUSH} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  dir;       // 1 = read burst
  logic                  end_pend;  // frame ended while an APB transfer was in flight
  logic                  access_done;

`ifdef SPI_APB_WRAP_EN
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [15:0]           beat_cnt;
  logic [15:0]           next_cnt;
`else
  logic                  unused_wrap_length;
  assign unused_wrap_length = ^wrap_length;
`endif

  // Word address to byte address on the APB side.
  function automatic logic [APB_ADDR_WIDTH-1:0] word_to_paddr(input logic [ADDR_WIDTH-1:0] a);
    return APB_BASE + APB_ADDR_WIDTH'(a) * APB_ADDR_WIDTH'(BYTES);
  endfunction

  assign cmd_ready   = (state == IDLE);
  // A frame end in the same cycle wins: the offered word is left unconsumed.
  assign wr_ready    = (state == WR_WAIT) && !cs_end;
  assign rd_valid    = (state == RD_PUSH);
  assign access_done = (state == ACCESS) && pready;

  always_comb begin
    next_addr = cur_addr + ADDR_WIDTH'(1);
`ifdef SPI_APB_WRAP_EN
    next_cnt = beat_cnt + 16'd1;
    if ((wrap_length != '0) && (next_cnt == wrap_length)) begin
      next_addr = start_addr;
      next_cnt  = '0;
    end
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= APB_BASE;
      pwdata     <= '0;
      rd_data    <= '0;
      err_sticky <= 1'b0;
      cur_addr   <= '0;
      dir        <= 1'b0;
      end_pend   <= 1'b0;
`ifdef SPI_APB_WRAP_EN
      start_addr <= '0;
      beat_cnt   <= '0;
`endif
    end else begin
      // A new error in the same cycle as a clear must remain visible.
      if (access_done && pslverr)
        err_sticky <= 1'b1;
      else if (err_clr)
        err_sticky <= 1'b0;

      unique case (state)
        IDLE: begin
          end_pend <= 1'b0;
          if (cmd_valid) begin
            cur_addr <= cmd_addr;
            dir      <= cmd_rd_wr;
`ifdef SPI_APB_WRAP_EN
            start_addr <= cmd_addr;
            beat_cnt   <= '0;
`endif
            if (cmd_rd_wr) begin
              state   <= SETUP;
              psel    <= 1'b1;
              penable <= 1'b0;
              pwrite  <= 1'b0;
              paddr   <= word_to_paddr(cmd_addr);
            end else begin
              state <= WR_WAIT;
            end
          end
        end
        WR_WAIT: begin
          if (cs_end) begin
            state <= IDLE;
          end else if (wr_valid) begin
            state   <= SETUP;
            pwdata  <= wr_data;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= 1'b1;
            paddr   <= word_to_paddr(cur_addr);
          end
        end
        SETUP: begin
          if (cs_end) end_pend <= 1'b1;
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (cs_end) end_pend <= 1'b1;
          // The transfer is never aborted; a frame end only redirects the exit.
          if (pready) begin
            cur_addr <= next_addr;
`ifdef SPI_APB_WRAP_EN
            beat_cnt <= next_cnt;
`endif
            psel    <= 1'b0;
            penable <= 1'b0;
            if (dir) rd_data <= prdata;
            if (end_pend || cs_end)
              state <= IDLE;
            else
              state <= dir ? RD_PUSH : WR_WAIT;
          end
        end
        RD_PUSH: begin
          if (cs_end) begin
            state <= IDLE;
          end else if (rd_ready) begin
            state   <= SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            paddr   <= word_to_paddr(cur_addr);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_apb_sequencer.sv
module tb_spi_slave_apb_sequencer;

  localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef SPI_APB_WRAP_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  logic        sys_clk, sys_rst;
  logic        cmd_valid, cmd_ready, cmd_rd_wr;
  logic [11:0] cmd_addr;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid, rd_ready;
  logic [7:0]  rd_data;
  logic        cs_end;
  logic [15:0] wrap_length;
  logic        psel, penable, pwrite;
  logic [31:0] paddr;
  logic [7:0]  pwdata, prdata;
  logic        pready, pslverr;
  logic        err_sticky, err_clr;

  spi_slave_apb_sequencer #(
    .ADDR_WIDTH(12), .DATA_WIDTH(8), .APB_ADDR_WIDTH(32), .APB_BASE(BASE)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr), .cmd_addr(cmd_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .cs_end(cs_end), .wrap_length(wrap_length),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: word address of beat k of a burst starting at s.
  function automatic logic [11:0] ref_addr(input logic [11:0] s, input int unsigned k,
                                           input int unsigned wl);
    int unsigned off;
    off = (WRAP_ON && wl != 0) ? (k % wl) : k;
    return 12'((32'(s) + off) % 4096);
  endfunction

  // Read data the APB slave model returns for a given address.
  function automatic logic [7:0] pr_f(input logic [31:0] a);
    return a[7:0] ^ {a[3:0], a[11:8]} ^ 8'hC3;
  endfunction

  // APB slave model with programmable wait states and a record of every completed transfer.
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    logic        err;
  } rec_t;

  rec_t        mon_q[$];
  logic [7:0]  rd_ovr[$];
  int unsigned dly_min = 0, dly_max = 0, rsp_cnt = 0;
  bit          err_force = 1'b0, err_rand = 1'b0;

  always @(negedge sys_clk) begin
    if (psel && penable && !sys_rst) begin
      if (rsp_cnt == 0) begin
        pready  = 1'b1;
        prdata  = (rd_ovr.size() > 0) ? rd_ovr.pop_front() : pr_f(paddr);
        pslverr = err_force | (err_rand && ($urandom_range(0, 3) == 0));
        mon_q.push_back('{paddr, pwrite, pwdata, pslverr});
      end else begin
        rsp_cnt--;
        pready = 1'b0;
      end
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      rsp_cnt = $urandom_range(dly_max, dly_min);
    end
  end

  task automatic send_cmd(input logic rd, input logic [11:0] a);
    int unsigned i;
    i = 0;
    cmd_valid = 1'b1; cmd_rd_wr = rd; cmd_addr = a;
    while (!cmd_ready && i < 50) begin @(negedge sys_clk); i++; end
    check("cmd_accept", cmd_ready, 1);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wr_send(input logic [7:0] d);
    int unsigned i;
    i = 0;
    wr_valid = 1'b1; wr_data = d;
    while (!wr_ready && i < 50) begin @(negedge sys_clk); i++; end
    check("wr_accept", wr_ready, 1);
    @(negedge sys_clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_wr_ready();
    int unsigned i;
    i = 0;
    while (!wr_ready && i < 50) begin @(negedge sys_clk); i++; end
    check("wr_ready_wait", wr_ready, 1);
  endtask

  task automatic wait_rd_valid();
    int unsigned i;
    i = 0;
    while (!rd_valid && i < 50) begin @(negedge sys_clk); i++; end
    check("rd_valid_wait", rd_valid, 1);
  endtask

  task automatic cs_pulse();
    cs_end = 1'b1;
    @(negedge sys_clk);
    cs_end = 1'b0;
  endtask

  // One zero-wait write beat with cycle-exact checks of SETUP, ACCESS and the return to WR_WAIT.
  task automatic write_beat(input logic [7:0] d, input logic [11:0] a);
    wr_send(d);
    check("wb_setup_psel", psel, 1);
    check("wb_setup_penable", penable, 0);
    check("wb_setup_pwrite", pwrite, 1);
    check("wb_setup_paddr", paddr, BASE + 32'(a));
    check("wb_setup_pwdata", pwdata, d);
    @(negedge sys_clk);
    check("wb_access_penable", penable, 1);
    check("wb_access_paddr", paddr, BASE + 32'(a));
    @(negedge sys_clk);
    check("wb_wr_ready_again", wr_ready, 1);
    check("wb_psel_low", psel, 0);
  endtask

  logic [7:0]  wdat[8];
  logic        seen;
  int unsigned cnt;
  bit          exp_err;
  rec_t        r;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst = 1'b1; cmd_valid = 0; cmd_rd_wr = 0; cmd_addr = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0; cs_end = 0; wrap_length = '0; err_clr = 0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, BASE);
    check("rst_pwdata", pwdata, 0);
    check("rst_err", err_sticky, 0);

    // Write burst of three words
    send_cmd(1'b0, 12'h010);
    check("wr_wait_ready", wr_ready, 1);
    write_beat(8'hA1, 12'h010);
    write_beat(8'hA2, 12'h011);
    write_beat(8'hA3, 12'h012);
    cs_pulse();
    check("wr_end_idle", cmd_ready, 1);

    // Read burst with a stalled consumer
    rd_ovr.push_back(8'h55);
    rd_ovr.push_back(8'h66);
    send_cmd(1'b1, 12'h020);
    check("rd_setup_psel", psel, 1);
    check("rd_setup_penable", penable, 0);
    check("rd_setup_pwrite", pwrite, 0);
    check("rd_setup_paddr", paddr, BASE + 32'h20);
    @(negedge sys_clk);
    check("rd_access_penable", penable, 1);
    @(negedge sys_clk);
    check("rd_valid_first", rd_valid, 1);
    check("rd_data_first", rd_data, 8'h55);
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      check("rd_hold_valid", rd_valid, 1);
      check("rd_hold_data", rd_data, 8'h55);
      check("rd_hold_no_psel", psel, 0);
    end
    rd_ready = 1'b1;
    @(negedge sys_clk);
    rd_ready = 1'b0;
    check("rd2_setup_psel", psel, 1);
    check("rd2_setup_paddr", paddr, BASE + 32'h21);
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("rd_valid_second", rd_valid, 1);
    check("rd_data_second", rd_data, 8'h66);
    cs_pulse();
    check("rd_end_idle", cmd_ready, 1);
    check("rd_end_no_valid", rd_valid, 0);

    // Six writes with wrap length 4 (linear when the wrap feature is absent)
    wrap_length = 16'd4;
    send_cmd(1'b0, 12'h0FE);
    for (int k = 0; k < 6; k++) write_beat(8'(8'h30 + k), ref_addr(12'h0FE, k, 4));
    cs_pulse();
    wrap_length = '0;

    // Address roll-over at the top of the space
    send_cmd(1'b0, 12'hFFF);
    write_beat(8'hB0, 12'hFFF);
    write_beat(8'hB1, 12'h000);
    cs_pulse();

    // Frame end during a stretched ACCESS: transfer completes, then IDLE
    dly_min = 4; dly_max = 4;
    send_cmd(1'b0, 12'h040);
    wr_send(8'h3C);
    @(negedge sys_clk);
    cs_pulse();
    cnt = 0;
    while (psel && cnt < 20) begin @(negedge sys_clk); cnt++; end
    check("csend_access_len", cnt, 4);
    check("csend_idle", cmd_ready, 1);
    seen = 1'b0;
    repeat (3) begin @(negedge sys_clk); seen |= psel; end
    check("csend_no_psel", seen, 0);
    dly_min = 0; dly_max = 0;

    // Frame end with a same-cycle write word: word refused
    send_cmd(1'b0, 12'h100);
    wr_valid = 1'b1; wr_data = 8'h77; cs_end = 1'b1;
    #1;
    check("csend_wr_ready", wr_ready, 0);
    @(negedge sys_clk);
    wr_valid = 1'b0; cs_end = 1'b0;
    check("csend_wr_idle", cmd_ready, 1);
    check("csend_wr_pwdata", pwdata, 8'h3C);
    @(negedge sys_clk);
    check("csend_wr_no_psel", psel, 0);

    // Slave error with a same-cycle clear, then a later clear
    err_force = 1'b1;
    send_cmd(1'b0, 12'h200);
    wr_send(8'h99);
    @(negedge sys_clk);
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    err_force = 1'b0;
    check("err_set_wins", err_sticky, 1);
    check("err_continue", wr_ready, 1);
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    check("err_cleared", err_sticky, 0);

    // Reset in the middle of an ACCESS
    wr_send(8'h5A);
    @(negedge sys_clk);
    check("pre_rst_penable", penable, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("midrst_psel", psel, 0);
    check("midrst_penable", penable, 0);
    check("midrst_cmd_ready", cmd_ready, 1);

    // Randomized bursts against the reference model
    mon_q.delete();
    exp_err = 1'b0;
    err_rand = 1'b1;
    for (int b = 0; b < 30; b++) begin
      logic        rd;
      logic [11:0] sa;
      int unsigned beats, wl;
      rd    = 1'($urandom_range(0, 1));
      sa    = ($urandom_range(0, 3) == 0) ? 12'(12'hFFC + $urandom_range(0, 3)) : 12'($urandom);
      beats = $urandom_range(1, 6);
      wl    = $urandom_range(0, 5);
      wrap_length = 16'(wl);
      dly_min = 0; dly_max = $urandom_range(0, 2);
      send_cmd(rd, sa);
      if (!rd) begin
        for (int k = 0; k < int'(beats); k++) begin
          wdat[k] = 8'($urandom);
          wr_send(wdat[k]);
        end
        wait_wr_ready();
        cs_pulse();
      end else begin
        for (int k = 0; k < int'(beats); k++) begin
          wait_rd_valid();
          check("rnd_rd_data", rd_data, pr_f(BASE + 32'(ref_addr(sa, k, wl))));
          if (k < int'(beats) - 1) begin
            repeat ($urandom_range(0, 2)) @(negedge sys_clk);
            rd_ready = 1'b1;
            @(negedge sys_clk);
            rd_ready = 1'b0;
          end else begin
            cs_pulse();
          end
        end
      end
      check("rnd_idle", cmd_ready, 1);
      check("rnd_beats", mon_q.size(), beats);
      for (int k = 0; k < int'(beats) && mon_q.size() > 0; k++) begin
        r = mon_q.pop_front();
        check("rnd_paddr", r.addr, BASE + 32'(ref_addr(sa, k, wl)));
        check("rnd_pwrite", r.wr, !rd);
        if (!rd) check("rnd_pwdata", r.wdata, wdat[k]);
        exp_err |= r.err;
      end
      mon_q.delete();
      check("rnd_err_sticky", err_sticky, exp_err);
      if ($urandom_range(0, 2) == 0) begin
        err_clr = 1'b1;
        @(negedge sys_clk);
        err_clr = 1'b0;
        exp_err = 1'b0;
        check("rnd_err_clr", err_sticky, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
